// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//   Wishbone B4 pipelined initiator for a core data port. A core request
//   (req_i held with stable fields until gnt_o) becomes one single Wishbone
//   transfer. Only one transaction is outstanding at a time. A transfer that
//   sees no ack/err within TIMEOUT cycles of its first strobe is aborted and
//   reported as an error.
//
// Parameters
//   TIMEOUT  cycles from first stb to ack/err before abort (0 = never abort)
//   TO_W     width of the timeout counter (2**TO_W > TIMEOUT)
//
// Ports
//   wb_clk_i, wb_rst_i                 clock, async active-low reset
//   req_i, we_i, adr_i, dat_i, sel_i   core request and its fields
//   gnt_o                              request accepted this cycle (comb)
//   rvalid_o, rdata_o, err_o           completion pulse, read data, error
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_dat_o, wb_sel_o       Wishbone initiator outputs
//   wb_stall_i, wb_ack_i, wb_dat_i,
//   wb_err_i                           Wishbone responder inputs
// -----------------------------------------------------------------------------
module wb_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(TIMEOUT);
  localparam bit              LP_TO_EN   = (TIMEOUT != 32'd0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [TO_W-1:0]   w_to_cnt_inc;
  logic              w_busy;
  logic              w_grant;
  logic              w_resp;
  logic              w_timeout;

  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [31:0]       r_adr;
  logic [31:0]       r_dat;
  logic [3:0]        r_sel;
  logic              r_rvalid;
  logic              r_err;
  logic [31:0]       r_rdata;

  // Decode grant, responder completion and timeout expiry for this cycle
  always_comb begin
    w_busy  = (r_state == ST_REQ) || (r_state == ST_WAIT);
    w_grant = (r_state == ST_IDLE) && req_i;
    // ack/err only count once the strobe has been accepted
    w_resp  = (r_state == ST_WAIT) && (wb_ack_i || wb_err_i);
    if (r_to_cnt == {TO_W{1'b1}}) begin
      w_to_cnt_inc = r_to_cnt;
    end else begin
      w_to_cnt_inc = r_to_cnt + TO_W'(1);
    end
    // a response arriving on the expiry edge wins over the abort
    w_timeout = LP_TO_EN && w_busy && !w_resp && (w_to_cnt_inc == LP_TIMEOUT);
  end

  // Next-state logic of the IDLE -> REQ -> WAIT -> IDLE sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else if (!wb_stall_i) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (w_resp || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered bus outputs, timeout counter and completion pulses
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= 32'h0000_0000;
      r_dat    <= 32'h0000_0000;
      r_sel    <= 4'h0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0000_0000;
      r_to_cnt <= {TO_W{1'b0}};
    end else begin
      r_cyc    <= (w_state_nxt != ST_IDLE);
      r_stb    <= (w_state_nxt == ST_REQ);
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      if (w_grant) begin
        r_we     <= we_i;
        r_adr    <= adr_i;
        r_dat    <= dat_i;
        r_sel    <= sel_i;
        r_to_cnt <= {TO_W{1'b0}};
      end else if (w_resp || w_timeout) begin
        r_rvalid <= 1'b1;
        // timeout and response are exclusive, so wb_err_i only matters on a response
        r_err    <= w_timeout | wb_err_i;
        if (w_resp && !r_we && !wb_err_i) begin
          r_rdata <= wb_dat_i;
        end
        r_we  <= 1'b0;
        r_adr <= 32'h0000_0000;
        r_dat <= 32'h0000_0000;
        r_sel <= 4'h0;
      end else if (w_busy) begin
        r_to_cnt <= w_to_cnt_inc;
      end
    end
  end

  assign gnt_o    = w_grant;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;
  assign wb_we_o  = r_we;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;

endmodule

// File: tb/tb_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bridge
//   Self-checking bench for wb_master_bridge. A transaction-level model
//   (busy flag, strobe-pending flag, age in cycles) predicts every output each
//   cycle; directed scenarios add hand-computed literal expectations, then a
//   randomized phase drives requests and a responder with random stalls,
//   delays, errors, spurious acks and silent transfers.
// -----------------------------------------------------------------------------
module tb_wb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] adr_i = 32'h0;
  logic [31:0] dat_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_err_i = 1'b0;

  always #5 clk = ~clk;

  wb_master_bridge #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .sel_i      (sel_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stall_i (wb_stall_i),
    .wb_ack_i   (wb_ack_i),
    .wb_dat_i   (wb_dat_i),
    .wb_err_i   (wb_err_i)
  );

  int checks = 0;
  int failures = 0;

  // transaction-level model
  bit          m_busy;
  bit          m_stb_pend;
  int          m_age;
  bit          m_we;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  bit          m_rvalid;
  bit          m_err;
  logic [31:0] m_rdata;

  // random responder / requester state
  bit rs_pend = 1'b0;
  int rs_delay = 0;
  bit rs_never = 1'b0;
  bit rs_fire = 1'b0;
  bit hold_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_stb_pend = 1'b0; m_age = 0;
    m_we = 1'b0; m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0;
    m_rvalid = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic compare_model();
    chk("gnt",    32'(gnt_o),    32'(!m_busy && req_i));
    chk("cyc",    32'(wb_cyc_o), 32'(m_busy));
    chk("stb",    32'(wb_stb_o), 32'(m_busy && m_stb_pend));
    if (m_busy) begin
      chk("we",   32'(wb_we_o),  32'(m_we));
      chk("adr",  wb_adr_o,      m_adr);
    end
    chk("dat_o",  wb_dat_o,      m_busy ? m_dat : 32'h0);
    chk("sel_o",  32'(wb_sel_o), m_busy ? 32'(m_sel) : 32'h0);
    chk("rvalid", 32'(rvalid_o), 32'(m_rvalid));
    chk("err",    32'(err_o),    32'(m_err));
    chk("rdata",  rdata_o,       m_rdata);
  endtask

  // advance the model across one rising edge using the inputs now applied
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rvalid = 1'b0;
    m_err = 1'b0;
    if (!m_busy) begin
      if (req_i) begin
        m_busy = 1'b1; m_stb_pend = 1'b1; m_age = 0;
        m_we = we_i; m_adr = adr_i; m_dat = dat_i; m_sel = sel_i;
      end
    end else begin
      m_age++;
      if (!m_stb_pend && (wb_ack_i || wb_err_i)) begin
        m_rvalid = 1'b1;
        m_err = wb_err_i;
        if (!m_we && !wb_err_i) m_rdata = wb_dat_i;
        m_busy = 1'b0;
      end else if (TIMEOUT != 0 && m_age >= TIMEOUT) begin
        m_rvalid = 1'b1;
        m_err = 1'b1;
        m_busy = 1'b0;
      end else if (m_stb_pend && !wb_stall_i) begin
        m_stb_pend = 1'b0;
      end
    end
  endtask

  // first half of a cycle: let inputs settle, compare against the model
  task automatic tick_a();
    #1;
    compare_model();
  endtask

  // second half: update responder and model, wait for the next falling edge
  task automatic tick_b();
    hold_req = req_i && m_busy;
    if (rs_fire) rs_pend = 1'b0;
    else if (rs_pend && rs_delay > 0) rs_delay--;
    if (m_busy && m_stb_pend && !wb_stall_i) begin
      rs_pend = 1'b1;
      rs_delay = $urandom_range(0, 3);
      rs_never = ($urandom % 12) == 0;
    end
    model_update();
    if (!m_busy) rs_pend = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    tick_a();
    tick_b();
  endtask

  task automatic quiet_inputs();
    req_i = 1'b0; wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic set_req(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    req_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
  endtask

  task automatic drive_random();
    int k;
    if (!hold_req) begin
      req_i = ($urandom % 3) != 0;
      we_i  = 1'($urandom % 2);
      adr_i = {$urandom(), 2'b00} >> 2 << 2;
      dat_i = $urandom();
      sel_i = 4'($urandom_range(1, 15));
    end
    wb_stall_i = ($urandom % 3) == 0;
    wb_dat_i = $urandom();
    if (rs_pend && rs_delay == 0 && !rs_never) begin
      k = $urandom % 8;
      wb_ack_i = (k != 0);
      wb_err_i = (k < 2);
      rs_fire = 1'b1;
    end else begin
      wb_ack_i = ($urandom % 20) == 0;
      wb_err_i = 1'b0;
      rs_fire = 1'b0;
    end
  endtask

  initial begin
    bit ack_nx;
    model_reset();
    quiet_inputs();
    @(negedge clk);
    @(negedge clk);

    // reset state
    tick_a();
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    tick_b();
    rst_n = 1'b1;
    step();

    // 1: read 0x2010, registered ack returning 0x1234
    set_req(1'b0, 32'h0000_2010, 32'h0, 4'hF);
    tick_a(); chk("t1_gnt_T0", 32'(gnt_o), 32'h1); tick_b();
    req_i = 1'b0;
    tick_a(); chk("t1_stb_T1", 32'(wb_stb_o), 32'h1); chk("t1_adr_T1", wb_adr_o, 32'h0000_2010); tick_b();
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_1234;
    tick_a(); chk("t1_rvalid_T2", 32'(rvalid_o), 32'h0); tick_b();
    wb_ack_i = 1'b0;
    tick_a();
    chk("t1_rvalid_T3", 32'(rvalid_o), 32'h1);
    chk("t1_rdata_T3", rdata_o, 32'h0000_1234);
    chk("t1_err_T3", 32'(err_o), 32'h0);
    tick_b();

    // 2: write with 3 stall cycles
    set_req(1'b1, 32'h0000_2018, 32'hDEAD_BEEF, 4'b0101);
    tick_a(); chk("t2_gnt", 32'(gnt_o), 32'h1); tick_b();
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_stall_i = (i < 3);
      tick_a();
      chk("t2_stb_held", 32'(wb_stb_o), 32'h1);
      chk("t2_adr_held", wb_adr_o, 32'h0000_2018);
      chk("t2_dat_held", wb_dat_o, 32'hDEAD_BEEF);
      chk("t2_sel_held", 32'(wb_sel_o), 32'h5);
      tick_b();
    end
    wb_stall_i = 1'b0; wb_ack_i = 1'b1;
    tick_a(); chk("t2_stb_dropped", 32'(wb_stb_o), 32'h0); tick_b();
    wb_ack_i = 1'b0;
    tick_a(); chk("t2_rvalid", 32'(rvalid_o), 32'h1); chk("t2_rdata_kept", rdata_o, 32'h0000_1234); tick_b();
    tick_a(); chk("t2_rvalid_once", 32'(rvalid_o), 32'h0); tick_b();

    // 3: responder never answers -> timeout after 16 cycles of cyc
    set_req(1'b0, 32'h0000_2020, 32'h0, 4'hF);
    tick_a(); chk("t3_gnt", 32'(gnt_o), 32'h1); tick_b();
    req_i = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick_a(); chk("t3_cyc_held", 32'(wb_cyc_o), 32'h1); tick_b();
    end
    wb_ack_i = 1'b1;  // late ack, must be ignored
    tick_a();
    chk("t3_cyc_drop", 32'(wb_cyc_o), 32'h0);
    chk("t3_rvalid", 32'(rvalid_o), 32'h1);
    chk("t3_err", 32'(err_o), 32'h1);
    tick_b();
    wb_ack_i = 1'b0;
    set_req(1'b0, 32'h0000_2024, 32'h0, 4'hF);
    tick_a(); chk("t3_late_ack_rvalid", 32'(rvalid_o), 32'h0); chk("t3_next_gnt", 32'(gnt_o), 32'h1); tick_b();
    req_i = 1'b0;
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_0001;
    step();
    wb_ack_i = 1'b0;
    tick_a(); chk("t3_next_rdata", rdata_o, 32'hCAFE_0001); tick_b();

    // 4: ack together with err on a read
    set_req(1'b0, 32'h0000_2028, 32'h0, 4'hF);
    step();
    req_i = 1'b0;
    step();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h5555_5555;
    step();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick_a();
    chk("t4_rvalid", 32'(rvalid_o), 32'h1);
    chk("t4_err", 32'(err_o), 32'h1);
    chk("t4_rdata_kept", rdata_o, 32'hCAFE_0001);
    tick_b();

    // 5: req held for 4 back-to-back reads, registered-ack responder
    ack_nx = 1'b0;
    for (int t = 0; t < 13; t++) begin
      if (t < 10) set_req(1'b0, 32'h0000_3000 + 32'(t / 3) * 32'd4, 32'h0, 4'hF);
      else req_i = 1'b0;
      wb_ack_i = ack_nx;
      wb_dat_i = 32'h100 + 32'(t);
      tick_a();
      if (t < 10) chk("t5_gnt_pattern", 32'(gnt_o), 32'((t % 3) == 0));
      if (t == 12) begin
        chk("t5_last_rvalid", 32'(rvalid_o), 32'h1);
        chk("t5_last_rdata", rdata_o, 32'h0000_010B);
      end
      ack_nx = m_busy && m_stb_pend && !wb_stall_i;
      tick_b();
    end
    quiet_inputs();

    // 6: reset while in WAIT
    set_req(1'b0, 32'h0000_2030, 32'h0, 4'hF);
    step();
    req_i = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    tick_a();
    chk("t6_cyc", 32'(wb_cyc_o), 32'h0);
    chk("t6_stb", 32'(wb_stb_o), 32'h0);
    chk("t6_rvalid", 32'(rvalid_o), 32'h0);
    chk("t6_err", 32'(err_o), 32'h0);
    tick_b();
    rst_n = 1'b1;
    step();
    set_req(1'b0, 32'h0000_2034, 32'h0, 4'hF);
    tick_a(); chk("t6_gnt_after", 32'(gnt_o), 32'h1); tick_b();
    req_i = 1'b0;
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_6666;
    step();
    wb_ack_i = 1'b0;
    tick_a(); chk("t6_rvalid_after", 32'(rvalid_o), 32'h1); chk("t6_rdata_after", rdata_o, 32'h0000_6666); tick_b();

    // randomized phase
    hold_req = 1'b0;
    rs_pend = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      drive_random();
      step();
    end
    quiet_inputs();
    rs_fire = 1'b0;
    for (int n = 0; n < TIMEOUT + 4; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
